// File: rtl/chip8_tick_gen.sv
// Rate generator for the Chip-8 core: a 60 Hz timer timebase and a CPU instruction strobe.
// Fractional accumulators keep the average rates exact for any CLK_HZ.
module chip8_tick_gen #(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned TIMER_HZ       = 60,
    parameter int unsigned CPU_HZ_DEFAULT = 500,
    parameter int unsigned ACC_W          = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        cpu_rate_we,
    input  logic [10:0] cpu_rate,
    input  logic        step,
    output logic        clk_60,
    output logic        tick_60,
    output logic        cpu_tick,
    output logic [7:0]  frame_count,
    output logic [10:0] cpu_rate_cur
);

    // Twice the timer rate: each accumulator wrap is one half-period of clk_60.
    localparam logic [ACC_W-1:0] TimerInc    = ACC_W'(2 * TIMER_HZ);
    localparam logic [ACC_W-1:0] ClkLim      = ACC_W'(CLK_HZ);
    localparam logic [10:0]      RateDefault = 11'(CPU_HZ_DEFAULT);

    logic [ACC_W-1:0] acc_t_q, acc_t_d;
    logic [ACC_W-1:0] acc_c_q, acc_c_d;
    logic [ACC_W-1:0] sum_t, sum_c;
    logic             clk_60_q, clk_60_d;
    logic             tick_60_q, tick_60_d;
    logic             cpu_tick_q, cpu_tick_d;
    logic [7:0]       frame_q, frame_d;
    logic [10:0]      rate_q, rate_d;

    always_comb begin
        sum_t     = acc_t_q + TimerInc;
        acc_t_d   = acc_t_q;
        clk_60_d  = clk_60_q;
        tick_60_d = 1'b0;
        frame_d   = frame_q;
        if (enable) begin
            if (sum_t >= ClkLim) begin
                acc_t_d   = sum_t - ClkLim;
                clk_60_d  = ~clk_60_q;
                tick_60_d = ~clk_60_q;
                if (!clk_60_q) begin
                    frame_d = frame_q + 8'd1;
                end
            end else begin
                acc_t_d = sum_t;
            end
        end
    end

    // A rate write takes priority over both stepping and normal accumulation.
    always_comb begin
        sum_c      = acc_c_q + ACC_W'(rate_q);
        acc_c_d    = acc_c_q;
        cpu_tick_d = 1'b0;
        rate_d     = rate_q;
        if (cpu_rate_we) begin
            rate_d  = cpu_rate;
            acc_c_d = '0;
        end else if (rate_q == 11'd0) begin
            acc_c_d    = '0;
            cpu_tick_d = step;
        end else if (enable) begin
            if (sum_c >= ClkLim) begin
                acc_c_d    = sum_c - ClkLim;
                cpu_tick_d = 1'b1;
            end else begin
                acc_c_d = sum_c;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_t_q    <= '0;
            acc_c_q    <= '0;
            clk_60_q   <= 1'b0;
            tick_60_q  <= 1'b0;
            cpu_tick_q <= 1'b0;
            frame_q    <= 8'd0;
            rate_q     <= RateDefault;
        end else begin
            acc_t_q    <= acc_t_d;
            acc_c_q    <= acc_c_d;
            clk_60_q   <= clk_60_d;
            tick_60_q  <= tick_60_d;
            cpu_tick_q <= cpu_tick_d;
            frame_q    <= frame_d;
            rate_q     <= rate_d;
        end
    end

    assign clk_60       = clk_60_q;
    assign tick_60      = tick_60_q;
    assign cpu_tick     = cpu_tick_q;
    assign frame_count  = frame_q;
    assign cpu_rate_cur = rate_q;

endmodule

// File: tb/tb_chip8_tick_gen.sv
// Directed bench for chip8_tick_gen: CLK_HZ=1200 instance for the timing scenarios,
// CLK_HZ=1000 instance for fractional-rate and asynchronous-reset checks.
module tb_chip8_tick_gen;

    logic        clk = 1'b0;
    logic        reset, enable, cpu_rate_we, step;
    logic [10:0] cpu_rate;
    logic        clk_60, tick_60, cpu_tick;
    logic [7:0]  frame_count;
    logic [10:0] cpu_rate_cur;

    logic        reset2, enable2, cpu_rate_we2, step2;
    logic [10:0] cpu_rate2;
    logic        clk_60_2, tick_60_2, cpu_tick_2;
    logic [7:0]  frame_count_2;
    logic [10:0] cpu_rate_cur_2;

    int tests = 0;
    int fails = 0;
    int n     = 0;

    always #5 clk = ~clk;

    chip8_tick_gen #(
        .CLK_HZ(1200), .TIMER_HZ(60), .CPU_HZ_DEFAULT(100), .ACC_W(32)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .cpu_rate_we(cpu_rate_we),
        .cpu_rate(cpu_rate), .step(step), .clk_60(clk_60), .tick_60(tick_60),
        .cpu_tick(cpu_tick), .frame_count(frame_count), .cpu_rate_cur(cpu_rate_cur)
    );

    chip8_tick_gen #(
        .CLK_HZ(1000), .TIMER_HZ(60), .CPU_HZ_DEFAULT(100), .ACC_W(32)
    ) dut2 (
        .clk(clk), .reset(reset2), .enable(enable2), .cpu_rate_we(cpu_rate_we2),
        .cpu_rate(cpu_rate2), .step(step2), .clk_60(clk_60_2), .tick_60(tick_60_2),
        .cpu_tick(cpu_tick_2), .frame_count(frame_count_2), .cpu_rate_cur(cpu_rate_cur_2)
    );

    // Advance one edge and sample 1 time unit later; n numbers edges since reset release.
    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        enable      = 1'b1;
        cpu_rate_we = 1'b0;
        cpu_rate    = 11'd0;
        step        = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        n     = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b1;
        cpu_rate_we = 1'b0;
        cpu_rate = 11'd0;
        step = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({clk_60, tick_60, cpu_tick} !== 3'b000) begin
            fails++;
            $display("FAIL reset_strobes: got %b want 000", {clk_60, tick_60, cpu_tick});
        end
        tests++;
        if (frame_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_frame: got %0d want 0", frame_count);
        end
        tests++;
        if (cpu_rate_cur !== 11'd100) begin
            fails++;
            $display("FAIL reset_rate: got %0d want 100", cpu_rate_cur);
        end
    endtask

    task automatic test_timer();
        logic [2:0] exp;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            tick();
            exp = {((n / 10) % 2) == 1, (n % 20) == 10, (n % 12) == 0};
            tests++;
            if ({clk_60, tick_60, cpu_tick} !== exp) begin
                fails++;
                $display("FAIL timer edge %0d: got clk/tick/cpu %b want %b", n,
                         {clk_60, tick_60, cpu_tick}, exp);
            end
            if (n == 50) begin
                tests++;
                if (frame_count !== 8'd3) begin
                    fails++;
                    $display("FAIL timer_frame: got %0d want 3", frame_count);
                end
            end
            // Step while running (sampled on edge 5) must not add a tick.
            step = (n == 4);
        end
        tests++;
        if (cpu_rate_cur !== 11'd100) begin
            fails++;
            $display("FAIL timer_rate: got %0d want 100", cpu_rate_cur);
        end
    endtask

    task automatic test_rate_write();
        logic [2:0] exp;
        do_reset();
        cpu_rate = 11'd300;
        for (int i = 0; i < 50; i++) begin
            tick();
            exp[2] = ((n / 10) % 2) == 1;
            exp[1] = (n % 20) == 10;
            exp[0] = (n <= 30) ? ((n % 12) == 0) : (((n - 30) % 4) == 0);
            tests++;
            if ({clk_60, tick_60, cpu_tick} !== exp) begin
                fails++;
                $display("FAIL rate_write edge %0d: got clk/tick/cpu %b want %b", n,
                         {clk_60, tick_60, cpu_tick}, exp);
            end
            if (n == 30) begin
                tests++;
                if (cpu_rate_cur !== 11'd300) begin
                    fails++;
                    $display("FAIL rate_write_cur: got %0d want 300", cpu_rate_cur);
                end
            end
            cpu_rate_we = (n == 29);
        end
        cpu_rate_we = 1'b0;
    endtask

    task automatic test_halt();
        logic exp;
        int   pulses;
        pulses = 0;
        do_reset();
        cpu_rate = 11'd0;
        for (int i = 0; i < 210; i++) begin
            tick();
            exp = (n == 51) || (n == 61) || (n == 205);
            if (n <= 200 && cpu_tick === 1'b1) pulses++;
            tests++;
            if (cpu_tick !== exp) begin
                fails++;
                $display("FAIL halt edge %0d: got cpu_tick %b want %b", n, cpu_tick, exp);
            end
            if (n == 2) begin
                tests++;
                if (cpu_rate_cur !== 11'd0) begin
                    fails++;
                    $display("FAIL halt_rate: got %0d want 0", cpu_rate_cur);
                end
            end
            // Write on edge 2; steps sampled on 51, 61, 100 (with a write), 205 (disabled).
            cpu_rate_we = (n == 1) || (n == 99);
            step        = (n == 50) || (n == 60) || (n == 99) || (n == 204);
            enable      = (n < 200);
        end
        step = 1'b0;
        cpu_rate_we = 1'b0;
        enable = 1'b1;
        tests++;
        if (pulses != 2) begin
            fails++;
            $display("FAIL halt_pulse_count: got %0d want 2", pulses);
        end
    endtask

    task automatic test_enable();
        logic [2:0] exp;
        do_reset();
        for (int i = 0; i < 65; i++) begin
            tick();
            exp = {(n >= 10) && (n < 60), n == 10, (n == 12) || (n == 64)};
            tests++;
            if ({clk_60, tick_60, cpu_tick} !== exp) begin
                fails++;
                $display("FAIL enable edge %0d: got clk/tick/cpu %b want %b", n,
                         {clk_60, tick_60, cpu_tick}, exp);
            end
            // Edges 16..55 see enable=0.
            enable = !((n >= 15) && (n < 55));
        end
        tests++;
        if (frame_count !== 8'd1) begin
            fails++;
            $display("FAIL enable_frame: got %0d want 1", frame_count);
        end
    endtask

    task automatic test_fractional();
        logic prev_clk, prev_tick;
        int   last, ticks;
        logic seen_rise;
        prev_clk  = 1'b0;
        prev_tick = 1'b0;
        last      = 0;
        ticks     = 0;
        seen_rise = 1'b0;
        @(negedge clk);
        reset2 = 1'b1;
        n = 0;
        for (int i = 0; i < 6000; i++) begin
            tick();
            if (tick_60_2 === 1'b1) ticks++;
            if (clk_60_2 !== prev_clk) begin
                tests++;
                if ((n - last) < 8 || (n - last) > 9) begin
                    fails++;
                    $display("FAIL frac_half_period at edge %0d: got %0d want 8..9", n, n - last);
                end
                if (!seen_rise) begin
                    seen_rise = 1'b1;
                    tests++;
                    if (n != 9) begin
                        fails++;
                        $display("FAIL frac_first_rise: got edge %0d want 9", n);
                    end
                end
                last = n;
            end
            if (tick_60_2 === 1'b1 && prev_tick === 1'b1) begin
                tests++;
                fails++;
                $display("FAIL frac_tick_width at edge %0d: got 2+ cycles want 1", n);
            end
            prev_clk  = clk_60_2;
            prev_tick = tick_60_2;
        end
        tests++;
        if (ticks != 360) begin
            fails++;
            $display("FAIL frac_tick_count: got %0d want 360", ticks);
        end
        tests++;
        if (frame_count_2 !== 8'd104) begin
            fails++;
            $display("FAIL frac_frame_wrap: got %0d want 104", frame_count_2);
        end
    endtask

    task automatic test_async_reset();
        cpu_rate2    = 11'd300;
        cpu_rate_we2 = 1'b1;
        tick();
        cpu_rate_we2 = 1'b0;
        for (int k = 0; k < 40 && clk_60_2 !== 1'b1; k++) tick();
        tests++;
        if (clk_60_2 !== 1'b1) begin
            fails++;
            $display("FAIL async_wait_clk60: got %b want 1 within 40 cycles", clk_60_2);
        end
        // Assert reset between edges; outputs must clear with no clock edge.
        #2;
        reset2 = 1'b0;
        #1;
        tests++;
        if ({clk_60_2, tick_60_2, cpu_tick_2} !== 3'b000 || frame_count_2 !== 8'd0) begin
            fails++;
            $display("FAIL async_reset_outputs: got %b frame %0d want 000 frame 0",
                     {clk_60_2, tick_60_2, cpu_tick_2}, frame_count_2);
        end
        tests++;
        if (cpu_rate_cur_2 !== 11'd100) begin
            fails++;
            $display("FAIL async_reset_rate: got %0d want 100", cpu_rate_cur_2);
        end
    endtask

    initial begin
        reset2       = 1'b0;
        enable2      = 1'b1;
        cpu_rate_we2 = 1'b0;
        cpu_rate2    = 11'd0;
        step2        = 1'b0;
        test_reset();
        test_timer();
        test_rate_write();
        test_halt();
        test_enable();
        test_fractional();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/chip8_tick_gen.md
Name: chip8_tick_gen

Overview:
- Upstream rate generator for the Chip-8 core.
- Derives the 60 Hz timebase (`clk_60` square wave plus a `tick_60` strobe) that drives the delay and sound timers from the single system clock.
- Also produces the CPU instruction-rate strobe `cpu_tick`, with run-time rate control, halt and single-step.
- Uses fractional accumulators, so average rates are exact even when CLK_HZ is not an integer multiple of the target rate.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- TIMER_HZ, 60, timer tick frequency in Hz.
- CPU_HZ_DEFAULT, 500, CPU tick rate loaded at reset, in Hz.
- ACC_W, 32, accumulator width. Must hold CLK_HZ + max(2*TIMER_HZ, 2047).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = generator runs; 0 = both accumulators frozen, level outputs hold.
- cpu_rate_we  in  1  single-cycle write strobe for cpu_rate.
- cpu_rate  in  11  new CPU rate in Hz; 0 = halt.
- step  in  1  single-cycle pulse; issues one cpu_tick while halted.
- clk_60  out  1  TIMER_HZ square wave, consumed as the timers' clk_60.
- tick_60  out  1  one-cycle strobe on each clk_60 0->1 transition.
- cpu_tick  out  1  one-cycle CPU-rate strobe.
- frame_count  out  8  count of tick_60 strobes, wraps 255->0.
- cpu_rate_cur  out  11  currently active CPU rate.

Behaviour:
- Reset (async assert, sync deassert, active-low) sets:
  - clk_60=0, tick_60=0, cpu_tick=0, frame_count=0.
  - Both accumulators = 0.
  - cpu_rate_cur = CPU_HZ_DEFAULT.
  - Reset asserted mid-period discards all accumulated phase.
- All outputs are registered. No combinational path exists from any input to any output.
- Timer accumulator (acc_t), evaluated each edge with enable=1:
  - sum = acc_t + 2*TIMER_HZ.
  - If sum >= CLK_HZ: acc_t <= sum - CLK_HZ and clk_60 toggles. Otherwise acc_t <= sum.
  - tick_60 = 1 for exactly the cycle in which the registered clk_60 has just gone 0->1. It is set on the same edge as the toggle.
  - frame_count increments on that same edge.
  - The first clk_60 rise follows the N-th edge after reset release, N = ceil(CLK_HZ / (2*TIMER_HZ)).
- CPU accumulator (acc_c), evaluated with enable=1 and cpu_rate_cur != 0:
  - sum = acc_c + cpu_rate_cur.
  - If sum >= CLK_HZ: acc_c <= sum - CLK_HZ and cpu_tick <= 1. Otherwise cpu_tick <= 0.
- Rate write:
  - cpu_rate_we=1 on edge k gives cpu_rate_cur = cpu_rate after edge k, and acc_c is cleared.
  - No cpu_tick is issued on edge k.
  - The new rate governs from edge k+1.
  - The timer path is unaffected.
- Halt (cpu_rate_cur = 0):
  - acc_c holds 0.
  - cpu_tick = 1 only on the edge after a step pulse. This works regardless of enable.
  - step while cpu_rate_cur != 0 is ignored.
  - step coinciding with cpu_rate_we: the write wins, and step is ignored.
- enable=0:
  - Both accumulators, clk_60 and frame_count hold.
  - tick_60=0 and cpu_tick=0, except for the step tick while halted.
  - Re-enabling resumes from the held phase, with no lost or extra tick.
- Strobes never exceed one cycle. Back-to-back cpu_tick is legal only if cpu_rate_cur >= CLK_HZ/2, which is unreachable at the default parameters.
- Average rates are exact:
  - clk_60 period averages CLK_HZ/TIMER_HZ cycles, with ±1 cycle jitter per half-period.
  - cpu_tick spacing averages CLK_HZ/cpu_rate_cur cycles.

Test Plan (bench parameters CLK_HZ=1200, TIMER_HZ=60, CPU_HZ_DEFAULT=100):
- Release reset, enable=1 -> clk_60 rises after edge 10, falls after edge 20, and has period 20. tick_60 pulses one cycle at edges 10, 30, 50. frame_count reads 3 after edge 50.
- Same run -> cpu_tick pulses at edges 12, 24, 36, each one cycle wide, and cpu_rate_cur=100.
- At edge 30 write cpu_rate=300 -> no cpu_tick at edge 30; cpu_tick at edges 34, 38, 42. The clk_60 edges are unchanged.
- Write cpu_rate=0, then pulse step at edges 50 and 60 -> exactly two cpu_tick pulses, at edges 51 and 61, and none otherwise over 200 cycles.
- Drop enable at edge 15 for 40 cycles -> clk_60 holds 1 and no tick_60 occurs. After re-enable the next clk_60 fall comes 5 edges later.
- Rebuild with CLK_HZ=1000 and run 6000 cycles -> 360 tick_60 pulses, each half-period 8 or 9 cycles. Asserting reset mid-run clears all outputs immediately, without waiting for clk.
